// File: rtl/ps_readout_ctrl.sv
// Run sequencer for the Parallel_Serial capture block: issues per-frame start pulses,
// tracks frame completion from FIFO write strobes, and reports run status and errors.
module ps_readout_ctrl #(
  parameter int unsigned WORDS_PER_FRAME = 10,
  parameter int unsigned TIMEOUT         = 1024,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [CNT_W-1:0] n_frames,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic             mode_in,
  input  logic             fifo_full,
  input  logic             fifo_prog_full,
  input  logic             ps_wr_en,
  output logic             ps_start,
  output logic             ps_mode,
  output logic             ps_clr,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_overflow,
  output logic             err_timeout,
  output logic             done
);

  localparam int unsigned WW = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StCapture,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nf_q, nf_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             stop_q, stop_d;
  logic             mode_q, mode_d;
  logic             ov_q, ov_d;
  logic             to_q, to_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             frame_end;
  logic             run_end;

  assign frame_end = ps_wr_en && (wcnt_q == WW'(WORDS_PER_FRAME - 1));
  // A stop seen on the completing edge itself ends the run just like a pending one.
  assign run_end   = ((nf_q != '0) && (fcnt_d == nf_q)) || stop_q || cmd_stop;

  always_comb begin
    state_d = state_q;
    nf_d    = nf_q;
    gcnt_d  = gcnt_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    stop_d  = stop_q;
    mode_d  = mode_q;
    ov_d    = ov_q;
    to_d    = to_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_start && !cmd_stop) begin
          state_d = StArm;
          mode_d  = mode_in;
          nf_d    = n_frames;
          fcnt_d  = '0;
          ov_d    = 1'b0;
          to_d    = 1'b0;
          stop_d  = 1'b0;
        end
      end
      StArm: begin
        if (cmd_stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (!fifo_prog_full) begin
          state_d = StFire;
        end
      end
      StFire: begin
        state_d = StCapture;
        wcnt_d  = '0;
        tcnt_d  = '0;
        if (cmd_stop) stop_d = 1'b1;
      end
      StCapture: begin
        if (cmd_stop) stop_d = 1'b1;
        if (fifo_full) ov_d = 1'b1;
        tcnt_d = tcnt_q + TW'(1);
        if (ps_wr_en) wcnt_d = wcnt_q + WW'(1);
        if (frame_end) begin
          fcnt_d = fcnt_q + CNT_W'(1);
          if (run_end) begin
            state_d = StIdle;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else if (gap_cycles == '0) begin
            state_d = StArm;
          end else begin
            state_d = StGap;
            gcnt_d  = gap_cycles - CNT_W'(1);
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Abort: the partial frame is discarded and the serializer is cleared.
          state_d = StIdle;
          clr_d   = 1'b1;
          to_d    = 1'b1;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end
      end
      StGap: begin
        if (cmd_stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (gcnt_q == '0) begin
          state_d = StArm;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    start_d = (state_d == StFire);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      nf_q    <= '0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      stop_q  <= 1'b0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nf_q    <= nf_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      stop_q  <= stop_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
      to_q    <= to_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign ps_start     = start_q;
  assign ps_mode      = mode_q;
  assign ps_clr       = clr_q;
  assign busy         = busy_q;
  assign frame_cnt    = fcnt_q;
  assign err_overflow = ov_q;
  assign err_timeout  = to_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ps_readout_ctrl.sv
// Directed bench for ps_readout_ctrl with a simple serializer model and a run scoreboard
// that is checked on every done pulse.
module tb_ps_readout_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WPF   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_start, cmd_stop;
  logic [CNT_W-1:0] n_frames, gap_cycles;
  logic             mode_in, fifo_full, fifo_prog_full, ps_wr_en;
  logic             ps_start, ps_mode, ps_clr, busy, err_overflow, err_timeout, done;
  logic [CNT_W-1:0] frame_cnt;

  ps_readout_ctrl #(
    .WORDS_PER_FRAME(WPF),
    .TIMEOUT        (1024),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .n_frames      (n_frames),
    .gap_cycles    (gap_cycles),
    .mode_in       (mode_in),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .ps_wr_en      (ps_wr_en),
    .ps_start      (ps_start),
    .ps_mode       (ps_mode),
    .ps_clr        (ps_clr),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   frames;
    logic ov;
    logic to;
    int   starts;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   runs = 0;
  int   done_seen = 0;
  int   start_total = 0;
  int   run_starts = 0;
  logic prev_start = 1'b0;
  logic prev_done = 1'b0;
  logic ser_en = 1'b1;
  int   ser_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serializer model: WPF write strobes starting one cycle after the start pulse.
  always @(negedge clk) begin
    if (ser_left != 0) begin
      ps_wr_en = 1'b1;
      ser_left--;
    end else begin
      ps_wr_en = 1'b0;
    end
    if (ps_start && ser_en) ser_left = WPF;
  end

  // Scoreboard side: every done pulse pops and checks one expected run result.
  always @(negedge clk) begin
    if (!rst) run_starts = 0;
    if (ps_start) begin
      check("start_width", prev_start, 1'b0);
      run_starts++;
      start_total++;
    end
    if (done) begin
      check("done_width", prev_done, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("run_frame_cnt", frame_cnt, e.frames);
        check("run_err_overflow", err_overflow, e.ov);
        check("run_err_timeout", err_timeout, e.to);
        check("run_busy_low", busy, 1'b0);
        check("run_start_pulses", run_starts, e.starts);
      end
      run_starts = 0;
      done_seen++;
    end
    prev_start = ps_start;
    prev_done  = done;
  end

  task automatic expect_run(input int frames, input logic ov, input logic to, input int starts);
    exp_t e;
    e.frames = frames;
    e.ov     = ov;
    e.to     = to;
    e.starts = starts;
    sb.push_back(e);
    runs++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 cmd_stop = 1'b1;
    @(posedge clk); #1 cmd_stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && done_seen < runs; i++) @(posedge clk);
    check(tag, done_seen >= runs, 1'b1);
  endtask

  initial begin
    int base, n, dseen;
    rst = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; n_frames = '0; gap_cycles = '0;
    mode_in = 1'b0; fifo_full = 1'b0; fifo_prog_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ps_start", ps_start, 1'b0);
    check("rst_ps_mode", ps_mode, 1'b0);
    check("rst_ps_clr", ps_clr, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_ov", err_overflow, 1'b0);
    check("rst_err_to", err_timeout, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: three frames with gaps, latency of the first start pulse
    n_frames = 3; gap_cycles = 4; mode_in = 1'b1;
    expect_run(3, 1'b0, 1'b0, 3);
    dseen = done_seen;
    pulse_start();
    @(negedge clk);
    check("t1_arm_busy", busy, 1'b1);
    check("t1_arm_no_start", ps_start, 1'b0);
    @(negedge clk);
    check("t1_fire_start", ps_start, 1'b1);
    check("t1_ps_mode", ps_mode, 1'b1);
    wait_done("t1_done_seen", 200);
    repeat (5) @(posedge clk);
    check("t1_one_done", done_seen - dseen, 1);
    check("t1_busy_after", busy, 1'b0);

    // 2: almost-full holds off the start pulse
    n_frames = 1; mode_in = 1'b0; fifo_prog_full = 1'b1;
    expect_run(1, 1'b0, 1'b0, 1);
    base = start_total;
    pulse_start();
    repeat (20) @(posedge clk);
    check("t2_held_off", start_total - base, 0);
    #1 fifo_prog_full = 1'b0;
    @(negedge clk);
    check("t2_not_yet", ps_start, 1'b0);
    @(negedge clk);
    check("t2_start_after_fall", ps_start, 1'b1);
    check("t2_ps_mode", ps_mode, 1'b0);
    wait_done("t2_done_seen", 100);

    // 3: continuous mode stopped during the fifth frame
    n_frames = 0; gap_cycles = 2;
    expect_run(5, 1'b0, 1'b0, 5);
    base = start_total;
    pulse_start();
    for (int i = 0; i < 300 && start_total - base < 5; i++) @(posedge clk);
    check("t3_five_starts", start_total - base, 5);
    repeat (2) @(posedge clk);
    pulse_stop();
    wait_done("t3_done_seen", 100);
    base = start_total;
    repeat (30) @(posedge clk);
    check("t3_no_more_starts", start_total - base, 0);

    // 4: no write strobes, capture times out
    ser_en = 1'b0; n_frames = 1;
    expect_run(0, 1'b0, 1'b1, 1);
    pulse_start();
    n = 0;
    for (int i = 0; i < 20 && !ps_start; i++) @(negedge clk);
    check("t4_fired", ps_start, 1'b1);
    for (int i = 0; i < 2000 && !ps_clr; i++) begin
      @(negedge clk);
      n++;
    end
    check("t4_clr_delay", n, 1025);
    @(negedge clk);
    check("t4_clr_one_cycle", ps_clr, 1'b0);
    check("t4_err_to_sticky", err_timeout, 1'b1);
    wait_done("t4_done_seen", 10);
    ser_en = 1'b1;

    // 5: overflow flag is sticky until the next accepted start
    n_frames = 2; gap_cycles = 0;
    expect_run(2, 1'b1, 1'b0, 2);
    pulse_start();
    for (int i = 0; i < 20 && !ps_start; i++) @(negedge clk);
    @(posedge clk); #1 fifo_full = 1'b1;
    @(posedge clk); #1 fifo_full = 1'b0;
    @(negedge clk);
    check("t5_ov_set", err_overflow, 1'b1);
    wait_done("t5_done_seen", 100);
    repeat (5) @(posedge clk);
    check("t5_ov_held", err_overflow, 1'b1);
    n_frames = 1;
    expect_run(1, 1'b0, 1'b0, 1);
    pulse_start();
    @(negedge clk);
    check("t5_ov_cleared", err_overflow, 1'b0);
    check("t5_to_cleared", err_timeout, 1'b0);
    wait_done("t5b_done_seen", 100);

    // 6: ignored start mid-run, reset during capture, start+stop together in idle
    n_frames = 0; gap_cycles = 0; mode_in = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && frame_cnt != 1; i++) @(negedge clk);
    check("t6_first_frame", frame_cnt, 1);
    repeat (4) @(posedge clk);
    pulse_start();
    @(negedge clk);
    check("t6_start_ignored_cnt", frame_cnt, 1);
    check("t6_start_ignored_busy", busy, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    check("t6_rst_ps_mode", ps_mode, 1'b0);
    check("t6_rst_ps_start", ps_start, 1'b0);
    check("t6_rst_done", done, 1'b0);
    base = start_total;
    @(posedge clk); #1 cmd_start = 1'b1; cmd_stop = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0; cmd_stop = 1'b0;
    @(negedge clk);
    check("t6_both_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    check("t6_both_no_start", start_total - base, 0);
    check("t6_both_mode", ps_mode, 1'b0);
    check("t6_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps_readout_ctrl.md
Name: ps_readout_ctrl

Overview:
- Run sequencer for the Parallel_Serial capture block.
- Accepts software run commands and issues one-cycle start pulses to the serializer, one per frame.
- Counts the FIFO write strobes the serializer produces to detect frame completion, inserts programmable gaps between frames, and throttles on FIFO almost-full.
- Reports busy, frame count, and sticky overflow/timeout errors to the register bank.

Parameters:
WORDS_PER_FRAME, 10, ps_wr_en pulses that complete one frame; must equal the serializer's NDATA.
TIMEOUT, 1024, maximum cycles allowed in CAPTURE before abort.
CNT_W, 16, width of n_frames, gap_cycles and frame_cnt.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-low reset
cmd_start  in  1  one-cycle pulse; begins a run
cmd_stop  in  1  one-cycle pulse; ends the run
n_frames  in  CNT_W  frames per run; 0 = continuous until cmd_stop
gap_cycles  in  CNT_W  idle cycles between frames
mode_in  in  1  serializer mode; latched at run start
fifo_full  in  1  FIFO full flag
fifo_prog_full  in  1  FIFO almost-full flag
ps_wr_en  in  1  fifo_wr_en from the serializer (monitored only)
ps_start  out  1  start pulse to the serializer
ps_mode  out  1  latched mode to the serializer
ps_clr  out  1  active-high one-cycle clear to the serializer's rst
busy  out  1  high whenever state != IDLE
frame_cnt  out  CNT_W  frames completed in the current run
err_overflow  out  1  sticky; fifo_full seen during CAPTURE
err_timeout  out  1  sticky; CAPTURE timed out
done  out  1  one-cycle pulse at run end

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - All outputs are 0, including ps_mode, frame_cnt and both error flags.
  - All internal counters clear.
  - Reset has priority over any in-progress state.
- All outputs are registered.
- States are IDLE, ARM, FIRE, CAPTURE, GAP.
- IDLE:
  - cmd_start=1 and cmd_stop=0 -> ARM.
  - On that transition: latch ps_mode<=mode_in and n_frames; clear frame_cnt, err_overflow and err_timeout.
  - If cmd_start and cmd_stop are both 1, stop wins: no run starts and nothing changes.
- ARM:
  - Waits while fifo_prog_full=1.
  - When fifo_prog_full=0 -> FIRE.
  - cmd_stop -> IDLE and pulse done.
- FIRE:
  - Lasts exactly one cycle; ps_start=1 only in this state.
  - Then -> CAPTURE with word and timeout counters cleared.
- CAPTURE:
  - Each cycle with ps_wr_en=1 increments the word counter.
  - fifo_full=1 on any CAPTURE cycle sets err_overflow. The frame continues.
  - When the word count reaches WORDS_PER_FRAME, frame_cnt increments on that same edge. Then:
    - if n_frames!=0 and the new frame_cnt equals n_frames, or cmd_stop is pending -> IDLE with done;
    - otherwise, if gap_cycles=0 -> ARM;
    - otherwise -> GAP.
  - If the timeout counter reaches TIMEOUT before the frame completes: ps_clr=1 for one cycle, err_timeout<=1, -> IDLE with done. The frame is not counted.
  - A cmd_stop arriving in FIRE or CAPTURE is remembered as pending. The current frame finishes first.
- GAP:
  - Counts gap_cycles cycles, then -> ARM.
  - cmd_stop -> IDLE with done immediately.
- Ignored commands:
  - cmd_start is ignored in every state except IDLE.
  - cmd_stop is ignored in IDLE.
- frame_cnt wraps modulo 2^CNT_W in continuous mode with no error.
- Latency: cmd_start sampled at edge t -> ARM at t+1 -> ps_start high during cycle t+2 (when fifo_prog_full=0).
- done is registered and asserts on the cycle busy falls.
- Error flags hold until reset or the next accepted cmd_start.
- n_frames and gap_cycles may change during a run:
  - n_frames: the copy latched at run start is used.
  - gap_cycles: sampled on entry to GAP.

Test Plan:
1. n_frames=3, gap_cycles=4, serializer attached with NDATA=10 -> three ps_start pulses, each 1 cycle wide, 10 wr_en per frame; frame_cnt ends at 3; done pulses once; busy low afterwards; no errors.
2. fifo_prog_full=1 held for 20 cycles after cmd_start -> ps_start stays low; ps_start is asserted 1 cycle after fifo_prog_full falls.
3. n_frames=0, cmd_stop issued mid-CAPTURE of frame 5 -> frame 5 completes; frame_cnt=5; done pulses; no further ps_start.
4. ps_wr_en tied low, TIMEOUT=1024 -> ps_clr pulses once 1024 cycles into CAPTURE; err_timeout=1; frame_cnt=0; IDLE.
5. fifo_full pulsed 1 cycle during CAPTURE -> err_overflow=1 and remains set; the run completes; the next cmd_start clears it.
6. rst=0 asserted during CAPTURE -> next cycle all outputs are 0 and the state is IDLE; cmd_start issued during the run, and cmd_start+cmd_stop together in IDLE, are both ignored.
